rggen_avalon_width_adapter: RTL
===============================

Name: rggen_avalon_width_adapter

Overview:
- Avalon-MM bus-width down-converter between a wide Avalon host (upstream) and a narrower Avalon agent (downstream), e.g. a 64-bit CPU fabric driving a 32-bit rggen register block.
- Each upstream access splits into up to RATIO = HOST_BUS_WIDTH/AGENT_BUS_WIDTH sequential downstream beats; lanes with no enabled bytes are skipped.
- Read data is assembled and beat responses are merged before a single registered upstream completion.
- Optional abort of the remaining beats on an error response.

Parameters:
- ADDRESS_WIDTH, 16: byte-address width, same on both sides.
- HOST_BUS_WIDTH, 64: upstream data width; power of 2, ≥ AGENT_BUS_WIDTH.
- AGENT_BUS_WIDTH, 32: downstream data width; power of 2, ≥ 8.
- ABORT_ON_ERROR, 1: 1 = no further beats after a non-OKAY beat response; 0 = issue all enabled beats.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  synchronous active-low reset.
- i_read  in  1  upstream read request.
- i_write  in  1  upstream write request.
- i_address  in  ADDRESS_WIDTH  upstream byte address.
- i_byteenable  in  HOST_BUS_WIDTH/8  upstream byte enables.
- i_writedata  in  HOST_BUS_WIDTH  upstream write data.
- o_waitrequest  out  1  upstream stall; low for exactly one cycle at completion.
- o_response  out  2  upstream response: 00 OKAY, 10 SLVERR, 11 DECODEERROR.
- o_readdata  out  HOST_BUS_WIDTH  upstream read data, valid while o_waitrequest is low.
- o_ds_read  out  1  downstream read.
- o_ds_write  out  1  downstream write.
- o_ds_address  out  ADDRESS_WIDTH  downstream byte address.
- o_ds_byteenable  out  AGENT_BUS_WIDTH/8  downstream byte enables.
- o_ds_writedata  out  AGENT_BUS_WIDTH  downstream write data.
- i_ds_waitrequest  in  1  downstream stall.
- i_ds_response  in  2  downstream response, valid when i_ds_waitrequest is low.
- i_ds_readdata  in  AGENT_BUS_WIDTH  downstream read data, valid when i_ds_waitrequest is low.

Behaviour:
- Reset (i_rst_n low at a rising edge): state IDLE, o_waitrequest=1, o_response=00, o_readdata=0, all o_ds_* = 0, beat counter 0, capture registers 0.
- Reset asserted in any state takes effect at the next edge. Any in-flight access is dropped with no upstream completion. o_ds_read and o_ds_write are 0 from that edge.
- FSM states: IDLE, ACCESS, RESPOND. All outputs are registered or decoded from registered state.
- IDLE:
  - On (i_read | i_write), latch command, address aligned down to HOST_BUS_WIDTH/8 bytes, byteenable, writedata; clear the read-data accumulator; response register := 00.
  - i_read & i_write both high: response := 11, go directly to RESPOND, no downstream access.
  - Byteenable all zero: response 00, go directly to RESPOND, no downstream access.
  - Otherwise: beat index := lowest lane with a nonzero byteenable slice; go to ACCESS.
- ACCESS, beat k:
  - o_ds_read/o_ds_write = latched command.
  - o_ds_address = aligned address + k*(AGENT_BUS_WIDTH/8).
  - o_ds_byteenable and o_ds_writedata = lane k slices.
  - Signals held stable while i_ds_waitrequest=1.
- Beat completes in a cycle with i_ds_waitrequest=0:
  - On read, readdata lane k := i_ds_readdata.
  - Response register: keeps the first non-OKAY value. A later error does not overwrite it. Reserved code 01 is recorded as 10.
  - Next state: advance k to the next enabled lane, with no idle cycle between beats. Go to RESPOND if no enabled lanes remain, or if ABORT_ON_ERROR=1 and this beat's response is non-OKAY.
- Lanes not issued (skipped, aborted, or write) return 0 in o_readdata. Write completions return o_readdata=0.
- RESPOND: o_waitrequest=0 for one cycle with o_response and o_readdata; o_ds_* idle; next state IDLE. Readdata and response clear on return to IDLE.
- Upstream inputs are ignored outside IDLE. The host must hold its request until completion per Avalon rules. A new request can be accepted in the cycle after RESPOND.
- Latency with no downstream waits and n enabled beats: request seen at T0, beats T1..Tn, o_waitrequest low at Tn+1.
- RATIO=1 degenerates to a registered single-beat pass-through.

Test Plan (ADDRESS_WIDTH=16, HOST=64, AGENT=32, ABORT_ON_ERROR=1 unless noted):
1. Write addr 0x0013, be 0xFF, data 0x1122334455667788, ds waitrequest 0 -> beats (0x0010, be 0xF, 0x55667788), then (0x0014, be 0xF, 0x11223344); o_waitrequest low at T3; response 00.
2. Read addr 0x0008, be 0xF0, ds readdata 0xCAFEF00D -> single beat at 0x000C; o_readdata 0xCAFEF00D00000000; o_waitrequest low at T2.
3. Read be 0xFF; beat0 response 10, readdata 0xAAAA5555 -> no beat1; response 10; o_readdata 0x00000000AAAA5555. Repeat with ABORT_ON_ERROR=0, beat1 response 11 -> both beats issued; response 10.
4. Write be 0x00 -> no o_ds_write pulse; response 00; completion at T1. Read and write both high -> response 11; no downstream access.
5. Beat0 with i_ds_waitrequest held high 3 cycles -> o_ds_* stable throughout; beat1 follows on the cycle after release; completion at T6.
6. Reset asserted during beat1 -> next edge: o_ds_read/o_ds_write 0, o_waitrequest 1, o_readdata 0; no upstream completion; a fresh read after reset completes normally.

Source files
------------

// File: rtl/rggen_avalon_width_adapter.sv
// rggen_avalon_width_adapter: splits wide Avalon-MM accesses into narrower downstream beats
module rggen_avalon_width_adapter #(
    parameter int ADDRESS_WIDTH   = 16,
    parameter int HOST_BUS_WIDTH  = 64,
    parameter int AGENT_BUS_WIDTH = 32,
    parameter int ABORT_ON_ERROR  = 1
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_read,
    input  logic                         i_write,
    input  logic [ADDRESS_WIDTH-1:0]     i_address,
    input  logic [HOST_BUS_WIDTH/8-1:0]  i_byteenable,
    input  logic [HOST_BUS_WIDTH-1:0]    i_writedata,
    output logic                         o_waitrequest,
    output logic [1:0]                   o_response,
    output logic [HOST_BUS_WIDTH-1:0]    o_readdata,
    output logic                         o_ds_read,
    output logic                         o_ds_write,
    output logic [ADDRESS_WIDTH-1:0]     o_ds_address,
    output logic [AGENT_BUS_WIDTH/8-1:0] o_ds_byteenable,
    output logic [AGENT_BUS_WIDTH-1:0]   o_ds_writedata,
    input  logic                         i_ds_waitrequest,
    input  logic [1:0]                   i_ds_response,
    input  logic [AGENT_BUS_WIDTH-1:0]   i_ds_readdata
);
    localparam int RATIO = HOST_BUS_WIDTH / AGENT_BUS_WIDTH;
    localparam int HB    = HOST_BUS_WIDTH / 8;
    localparam int AB    = AGENT_BUS_WIDTH / 8;
    localparam int AS    = $clog2(AB);
    localparam int IW    = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [ADDRESS_WIDTH-1:0] ALIGN_MASK = ~ADDRESS_WIDTH'(HB - 1);

    typedef enum logic [1:0] {IDLE, ACCESS, RESPOND} state_e;

    state_e                      state_q, state_d;
    logic                        write_q, write_d;
    logic [ADDRESS_WIDTH-1:0]    addr_q, addr_d;
    logic [HB-1:0]               be_q, be_d;
    logic [HOST_BUS_WIDTH-1:0]   wd_q, wd_d;
    logic [HOST_BUS_WIDTH-1:0]   rdata_q, rdata_d;
    logic [1:0]                  resp_q, resp_d;
    logic [IW-1:0]               idx_q, idx_d;
    logic [RATIO-1:0]            lane_en_new, lane_en_cur;
    logic [IW-1:0]               first_lane, next_lane;
    logic                        has_next;
    logic [1:0]                  ds_resp;
    logic                        access;

    assign ds_resp = (i_ds_response == 2'b01) ? 2'b10 : i_ds_response;
    assign access  = (state_q == ACCESS);

    // lanes that carry at least one enabled byte, for a new request and for the latched one
    always_comb begin
        lane_en_new = '0;
        lane_en_cur = '0;
        for (int j = 0; j < RATIO; j++) begin
            lane_en_new[j] = |i_byteenable[j*AB +: AB];
            lane_en_cur[j] = |be_q[j*AB +: AB];
        end
    end

    // lowest enabled lane of a new request and the next enabled lane after the current beat
    always_comb begin
        first_lane = '0;
        next_lane  = '0;
        has_next   = 1'b0;
        for (int j = RATIO - 1; j >= 0; j--) begin
            if (lane_en_new[j]) first_lane = IW'(j);
            if (lane_en_cur[j] && j > int'(idx_q)) begin
                next_lane = IW'(j);
                has_next  = 1'b1;
            end
        end
    end

    // command capture, beat sequencing, read assembly and response merge
    always_comb begin
        state_d = state_q;
        write_d = write_q;
        addr_d  = addr_q;
        be_d    = be_q;
        wd_d    = wd_q;
        rdata_d = rdata_q;
        resp_d  = resp_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: if (i_read || i_write) begin
                write_d = i_write;
                addr_d  = i_address & ALIGN_MASK;
                be_d    = i_byteenable;
                wd_d    = i_writedata;
                rdata_d = '0;
                resp_d  = 2'b00;
                idx_d   = first_lane;
                if (i_read && i_write) begin
                    resp_d  = 2'b11;
                    state_d = RESPOND;
                end else begin
                    state_d = (|i_byteenable) ? ACCESS : RESPOND;
                end
            end
            ACCESS: if (!i_ds_waitrequest) begin
                if (!write_q) rdata_d[idx_q*AGENT_BUS_WIDTH +: AGENT_BUS_WIDTH] = i_ds_readdata;
                if (resp_q == 2'b00) resp_d = ds_resp;
                idx_d   = next_lane;
                state_d = (!has_next || (ABORT_ON_ERROR != 0 && ds_resp != 2'b00)) ? RESPOND : ACCESS;
            end
            RESPOND: begin
                state_d = IDLE;
                rdata_d = '0;
                resp_d  = 2'b00;
            end
            default: state_d = IDLE;
        endcase
    end

    // state registers with synchronous active-low reset
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            write_q <= 1'b0;
            addr_q  <= '0;
            be_q    <= '0;
            wd_q    <= '0;
            rdata_q <= '0;
            resp_q  <= 2'b00;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wd_q    <= wd_d;
            rdata_q <= rdata_d;
            resp_q  <= resp_d;
            idx_q   <= idx_d;
        end
    end

    assign o_waitrequest   = (state_q != RESPOND);
    assign o_response      = resp_q;
    assign o_readdata      = rdata_q;
    assign o_ds_read       = access && !write_q;
    assign o_ds_write      = access && write_q;
    assign o_ds_address    = access ? addr_q + (ADDRESS_WIDTH'(idx_q) << AS) : '0;
    assign o_ds_byteenable = access ? be_q[idx_q*AB +: AB] : '0;
    assign o_ds_writedata  = access ? wd_q[idx_q*AGENT_BUS_WIDTH +: AGENT_BUS_WIDTH] : '0;
endmodule
